// File: rtl/piso_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : shift_pkg
// Description : State encoding and counter-width helper shared by the
//               parallel-in and serial-in shift chains.
// Revision    : 1.0
// ============================================================================
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // A one-bit counter is still needed when n is 1 or 2.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Interface   : piso_shift_reg_if
// Description : Parallel word handshake and framed serial output of the PISO.
// Revision    : 1.0
// ============================================================================
interface piso_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, sout_first, sout_last
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, sout_first, sout_last
    );
endinterface
`default_nettype wire

// File: rtl/piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : piso_shift_reg
// Description : Parallel-in serial-out shifter with valid/ready word input
//               and first/last framing strobes; back-to-back words stream
//               without a bubble.
// Revision    : 1.0
// ============================================================================
module piso_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    piso_shift_reg_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    piso_state_t      r_state;
    piso_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] w_sreg_shifted;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_shifting;
    logic             w_at_last;
    logic             w_ready;
    logic             w_accept;

    assign w_shifting = (r_state == SHIFT);
    assign w_at_last  = w_shifting && (r_cnt == c_last_cnt);
    assign w_ready    = (r_state == IDLE) || w_at_last;
    assign w_accept   = bus.din_valid && w_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign bus.sout       = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign bus.sout       = r_sreg[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Returning to IDLE clears the shadow word so sout reads 0 when idle.
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SHIFT;
                    w_sreg_nxt  = bus.din;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (!w_at_last) begin
                    w_sreg_nxt = w_sreg_shifted;
                    w_cnt_nxt  = r_cnt + CNT_W'(1);
                end else if (w_accept) begin
                    w_sreg_nxt = bus.din;
                    w_cnt_nxt  = '0;
                end else begin
                    w_state_nxt = IDLE;
                    w_sreg_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sreg_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.din_ready  = w_ready;
    assign bus.sout_valid = w_shifting;
    assign bus.sout_first = w_shifting && (r_cnt == '0);
    assign bus.sout_last  = w_at_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_shift_reg
// Description : Three PISO instances (8/MSB, 8/LSB, 2/MSB) against a bit-queue
//               model of the transmitted stream.
// Revision    : 1.0
// ============================================================================
module tb_piso_shift_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] din_d   [3];
    logic       valid_d [3];
    logic [4:0] obs     [3];
    int         checks   = 0;
    int         failures = 0;

    piso_shift_reg_if #(.WIDTH(8)) if0 ();
    piso_shift_reg_if #(.WIDTH(8)) if1 ();
    piso_shift_reg_if #(.WIDTH(2)) if2 ();

    assign if0.din = din_d[0];       assign if0.din_valid = valid_d[0];
    assign if1.din = din_d[1];       assign if1.din_valid = valid_d[1];
    assign if2.din = din_d[2][1:0];  assign if2.din_valid = valid_d[2];

    assign obs[0] = {if0.din_ready, if0.sout_valid, if0.sout, if0.sout_first, if0.sout_last};
    assign obs[1] = {if1.din_ready, if1.sout_valid, if1.sout, if1.sout_first, if1.sout_last};
    assign obs[2] = {if2.din_ready, if2.sout_valid, if2.sout, if2.sout_first, if2.sout_last};

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    piso_shift_reg #(.WIDTH(2), .MSB_FIRST(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    function automatic int wid(input int d);
        return (d == 2) ? 2 : 8;
    endfunction

    function automatic bit msbf(input int d);
        return d != 1;
    endfunction

    // Model: queue of bits still to be transmitted, entry = {bit, first, last},
    // entry 0 is the bit on the wire this cycle.
    typedef struct packed {
        logic [5:0]  n;
        logic [47:0] bits;
    } mstate_t;
    mstate_t mst [3];

    function automatic mstate_t model_next(input int d);
        mstate_t s;
        logic    acc;
        int      idx;
        s   = mst[d];
        acc = valid_d[d] && (s.n <= 6'd1);
        if (s.n != 6'd0) begin
            s.bits = s.bits >> 3;
            s.n    = s.n - 6'd1;
        end
        if (acc) begin
            for (int i = 0; i < wid(d); i++) begin
                idx = msbf(d) ? (wid(d) - 1 - i) : i;
                s.bits[3*s.n +: 3] = {din_d[d][idx], (i == 0), (i == wid(d) - 1)};
                s.n = s.n + 6'd1;
            end
        end
        return s;
    endfunction

    function automatic logic [4:0] exp_vec(input int d);
        if (mst[d].n == 6'd0) return 5'b10000;
        return {(mst[d].n == 6'd1), 1'b1, mst[d].bits[2:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) mst[d] <= '0;
            else        mst[d] <= model_next(d);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            valid_d[d] = 1'b1;
            din_d[d]   = 8'($urandom);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== 5'b10000) begin
                    failures++;
                    $display("FAIL reset d%0d cyc%0d: got %b want %b", d, c, obs[d], 5'b10000);
                end
            end
        end
        for (int d = 0; d < 3; d++) valid_d[d] = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_word();
        logic [7:0] got;
        got = '0;
        @(negedge clk);
        din_d[0] = 8'hA5; valid_d[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL single d%0d cyc%0d: got %b want %b", d, c, obs[d], exp_vec(d));
                end
            end
            if (c <= 8) got = {got[6:0], if0.sout};
            valid_d[0] = 1'b0;
        end
        checks++;
        if (got !== 8'hA5) begin
            failures++;
            $display("FAIL single_stream: got %h want %h", got, 8'hA5);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] got;
        got = '0;
        @(negedge clk);
        din_d[1] = 8'hA5; valid_d[1] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL lsb d%0d cyc%0d: got %b want %b", d, c, obs[d], exp_vec(d));
                end
            end
            if (c <= 8) got[c-1] = if1.sout;
            valid_d[1] = 1'b0;
        end
        checks++;
        if (got !== 8'hA5) begin
            failures++;
            $display("FAIL lsb_stream: got %h want %h", got, 8'hA5);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got, rdy, vld;
        got = '0; rdy = '0; vld = '0;
        @(negedge clk);
        din_d[0] = 8'hFF; valid_d[0] = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL b2b d%0d cyc%0d: got %b want %b", d, c, obs[d], exp_vec(d));
                end
            end
            if (c <= 16) begin
                got = {got[14:0], if0.sout};
                rdy = {rdy[14:0], if0.din_ready};
                vld = {vld[14:0], if0.sout_valid};
            end
            if (c == 1) din_d[0] = 8'h00;
            if (c == 9) valid_d[0] = 1'b0;
        end
        checks++;
        if (got !== 16'hFF00 || vld !== 16'hFFFF || rdy !== 16'h0101) begin
            failures++;
            $display("FAIL b2b_stream: got data=%h valid=%h ready=%h want %h %h %h",
                     got, vld, rdy, 16'hFF00, 16'hFFFF, 16'h0101);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got, rdy;
        got = '0; rdy = '0;
        @(negedge clk);
        din_d[0] = 8'h5A; valid_d[0] = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL backpressure d%0d cyc%0d: got %b want %b", d, c, obs[d], exp_vec(d));
                end
            end
            if (c <= 16) begin
                got = {got[14:0], if0.sout};
                rdy = {rdy[14:0], if0.din_ready};
            end
            if (c == 1) valid_d[0] = 1'b0;
            if (c == 3) begin din_d[0] = 8'h3C; valid_d[0] = 1'b1; end
            if (c == 9) valid_d[0] = 1'b0;
        end
        checks++;
        if (got !== 16'h5A3C || rdy !== 16'h0101) begin
            failures++;
            $display("FAIL backpressure_stream: got data=%h ready=%h want %h %h",
                     got, rdy, 16'h5A3C, 16'h0101);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        got = '0;
        @(negedge clk);
        din_d[0] = 8'hF0; valid_d[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            valid_d[0] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs[d] !== 5'b10000) begin
                failures++;
                $display("FAIL async_reset d%0d: got %b want %b", d, obs[d], 5'b10000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        din_d[0] = 8'h81; valid_d[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL post_reset d%0d cyc%0d: got %b want %b", d, c, obs[d], exp_vec(d));
                end
            end
            if (c <= 8) got = {got[6:0], if0.sout};
            valid_d[0] = 1'b0;
        end
        checks++;
        if (got !== 8'h81) begin
            failures++;
            $display("FAIL post_reset_stream: got %h want %h", got, 8'h81);
        end
    endtask

    task automatic test_min_width();
        logic [3:0] got, fst, lst;
        got = '0; fst = '0; lst = '0;
        @(negedge clk);
        din_d[2] = 8'h02; valid_d[2] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL min_width d%0d cyc%0d: got %b want %b", d, c, obs[d], exp_vec(d));
                end
            end
            if (c <= 4) begin
                got = {got[2:0], if2.sout};
                fst = {fst[2:0], if2.sout_first};
                lst = {lst[2:0], if2.sout_last};
            end
            if (c == 1) din_d[2] = 8'h01;
            if (c == 3) valid_d[2] = 1'b0;
        end
        checks++;
        if (got !== 4'b1001 || fst !== 4'b1010 || lst !== 4'b0101) begin
            failures++;
            $display("FAIL min_width_stream: got %b/%b/%b want %b/%b/%b",
                     got, fst, lst, 4'b1001, 4'b1010, 4'b0101);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL random d%0d cyc%0d: got %b want %b", d, c, obs[d], exp_vec(d));
                end
            end
            for (int d = 0; d < 3; d++) begin
                valid_d[d] = ($urandom_range(0, 3) != 0);
                din_d[d]   = 8'($urandom);
            end
        end
        for (int d = 0; d < 3; d++) valid_d[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            din_d[d]   = '0;
            valid_d[d] = 1'b0;
        end
        test_reset();
        test_single_word();
        test_lsb_first();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_min_width();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in, serial-out shift register that accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock with framing strobes. It is the transmit-side counterpart of our serial-in shift chains: words from a parallel datapath enter here and leave as a single-bit stream for a downstream serial consumer. The serial side has no backpressure; the block paces the parallel side with din_ready. Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8: word width in bits; legal range WIDTH ≥ 2.
- MSB_FIRST, 1: 1 shifts out din[WIDTH-1] first; 0 shifts out din[0] first.

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block accepts din this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a word bit this cycle.
- sout_first  output  1  sout is bit 0 of the frame (first transmitted).
- sout_last  output  1  sout is bit WIDTH-1 of the frame (last transmitted).

## Operation
- One clock; reset asynchronous, active-low.
- States: IDLE, SHIFT.
- Registers: shadow word sreg[WIDTH-1:0], bit counter cnt, width $clog2(WIDTH), counting 0..WIDTH-1.
- Accept = din_valid && din_ready.
- din_ready is combinational: 1 in IDLE; 1 in SHIFT only when cnt == WIDTH-1; 0 otherwise.
- IDLE + accept → SHIFT, load sreg = din, cnt = 0.
- IDLE + no accept → stay IDLE; sout_valid = 0.
- SHIFT, cnt < WIDTH-1 → shift sreg by one (left if MSB_FIRST, else right), cnt = cnt + 1. din is ignored.
- SHIFT, cnt == WIDTH-1 + accept → reload sreg = din, cnt = 0, stay in SHIFT. This is the zero-bubble back-to-back case.
- SHIFT, cnt == WIDTH-1 + no accept → IDLE.
- sout = sreg[WIDTH-1] if MSB_FIRST, else sreg[0]; all outputs come from registers.
- sout_valid = (state == SHIFT); sout_first = SHIFT && cnt == 0; sout_last = SHIFT && cnt == WIDTH-1.
- Vacated bit positions fill with 0.
- While sout_valid = 0, sout = 0.
- din_valid may drop without a transfer. A word is taken only on accept.

## Timing
- Reset values: state = IDLE, sreg = 0, cnt = 0.
  - Resulting outputs: sout = 0, sout_valid = 0, sout_first = 0, sout_last = 0, din_ready = 1.
  - While rst_n is low, din_valid has no effect.
- Latency: word accepted at edge t → first bit on sout during cycle t+1; last bit during cycle t+WIDTH.
- Throughput: one word per WIDTH cycles sustained. With din_valid held high, sout_valid stays 1 continuously.
- sout_first and sout_last are each high for exactly one cycle per word, WIDTH-1 cycles apart.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The partial word is discarded. The first accept after release starts a fresh frame.
- din_valid asserted when din_ready = 0: holds off, no data loss. The word is taken on the first edge where din_ready = 1.

## Structure
- Shared package shift_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
  - function clog2-based counter width helper, reused by the serial-in chains.
- Single module; no sub-module is natural. The datapath is one register plus a counter.

## Test plan
- Single word: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted once.
  - sout over 8 cycles = 1,0,1,0,0,1,0,1.
  - sout_first in cycle 1, sout_last in cycle 8.
  - Returns to IDLE; din_ready = 1 in cycle 9.
- LSB-first: MSB_FIRST=0, din=8'hA5 → sout = 1,0,1,0,0,1,0,1 reversed order: 1,0,1,0,0,1,0,1 read from bit 0.
  - Bench checks against din[i] per cycle i.
- Back-to-back: din_valid held high with 8'hFF then 8'h00.
  - 16 consecutive sout_valid cycles: eight 1s then eight 0s, no gap.
  - din_ready high only in cycles 8 and 16.
- Backpressure: din_valid=1 with din=8'h3C during cycle 3 of a frame.
  - No accept until cycle 8 (last bit).
  - 8'h3C follows immediately; the earlier word is unaltered.
- Reset mid-frame: rst_n low during bit 4 of 8'hF0.
  - sout, sout_valid, sout_first, sout_last go to 0 without waiting for a clock edge.
  - After release, din=8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- Minimum width: WIDTH=2, continuous din_valid with 2'b10, 2'b01 → sout = 1,0,0,1.
  - sout_first and sout_last alternate each cycle.
